// File: rtl/fetch_redirect_ctrl.sv
// rtl/fetch_redirect_ctrl.sv - irregular PC redirect sequencer for the fetch next-PC generator
//
// Collects trap / mispredict / replay redirect requests, arbitrates them by
// priority, holds the winner while fetch is stalled, presents it on irregPc
// for one unstalled cycle, then drives a timed flush of in-flight fetch
// stages. After reset the boot PC is issued the same way.
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   stall                       fetch stall (same as next-PC generator sees)
//   trapValid/trapTarget        trap redirect request, priority 2
//   mispredValid/mispredTarget  branch mispredict redirect, priority 1
//   replayValid/replayTarget    replay redirect, priority 0
//   irregPc                     redirect target, zero when no redirect
//   redirectIssue               pulse, redirect consumed this cycle
//   flushFetch                  kill in-flight fetch stages
//   busy                        a redirect is pending
//   dropped                     pulse, a valid request was discarded
//   badTarget                   sticky, a winning request had a bad target
module fetch_redirect_ctrl #(
    parameter int                    ADDR_WIDTH   = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC     = 32'h0000_1000,
    parameter int                    FLUSH_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  trapValid,
    input  logic [ADDR_WIDTH-1:0] trapTarget,
    input  logic                  mispredValid,
    input  logic [ADDR_WIDTH-1:0] mispredTarget,
    input  logic                  replayValid,
    input  logic [ADDR_WIDTH-1:0] replayTarget,
    output logic [ADDR_WIDTH-1:0] irregPc,
    output logic                  redirectIssue,
    output logic                  flushFetch,
    output logic                  busy,
    output logic                  dropped,
    output logic                  badTarget
);

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);
    localparam logic [1:0] PRIO_BOOT  = 2'd3;

    logic                  pend_valid_q, pend_valid_d;
    logic [ADDR_WIDTH-1:0] pend_target_q, pend_target_d;
    logic [1:0]            pend_prio_q, pend_prio_d;
    logic [3:0]            flush_cnt_q, flush_cnt_d;
    logic                  bad_target_q, bad_target_d;

    logic                  issue;
    logic                  win_valid;
    logic [ADDR_WIDTH-1:0] win_target;
    logic [1:0]            win_prio;
    logic                  win_bad;
    logic                  lose_drop;
    logic                  drop_pend;

    assign issue = pend_valid_q && !stall && !rst;

    // Fixed-priority pick among same-cycle requests; every valid loser is dropped.
    always_comb begin
        win_valid  = 1'b0;
        win_target = '0;
        win_prio   = 2'd0;
        lose_drop  = 1'b0;
        if (trapValid) begin
            win_valid  = 1'b1;
            win_target = trapTarget;
            win_prio   = 2'd2;
            lose_drop  = mispredValid || replayValid;
        end else if (mispredValid) begin
            win_valid  = 1'b1;
            win_target = mispredTarget;
            win_prio   = 2'd1;
            lose_drop  = replayValid;
        end else if (replayValid) begin
            win_valid  = 1'b1;
            win_target = replayTarget;
            win_prio   = 2'd0;
        end
    end

    // A bad winner is rejected outright; lower requests are not promoted in its place.
    assign win_bad = win_valid && ((win_target == '0) || (win_target[1:0] != 2'b00));

    always_comb begin
        pend_valid_d  = pend_valid_q;
        pend_target_d = pend_target_q;
        pend_prio_d   = pend_prio_q;
        flush_cnt_d   = flush_cnt_q;
        bad_target_d  = bad_target_q;
        drop_pend     = 1'b0;

        if (issue) begin
            pend_valid_d = 1'b0;
            flush_cnt_d  = FLUSH_LOAD;
        end else if ((flush_cnt_q != 4'd0) && !stall) begin
            flush_cnt_d = flush_cnt_q - 4'd1;
        end

        if (win_bad) begin
            bad_target_d = 1'b1;
        end else if (win_valid) begin
            // In the issue cycle the slot is being vacated, so the newcomer
            // is taken without comparing against the entry leaving it.
            if (issue || !pend_valid_q ||
                ((pend_prio_q != PRIO_BOOT) && (win_prio >= pend_prio_q))) begin
                pend_valid_d  = 1'b1;
                pend_target_d = win_target;
                pend_prio_d   = win_prio;
            end else begin
                drop_pend = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_valid_q  <= 1'b1;
            pend_target_q <= RESET_PC;
            pend_prio_q   <= PRIO_BOOT;
            flush_cnt_q   <= 4'd0;
            bad_target_q  <= 1'b0;
        end else begin
            pend_valid_q  <= pend_valid_d;
            pend_target_q <= pend_target_d;
            pend_prio_q   <= pend_prio_d;
            flush_cnt_q   <= flush_cnt_d;
            bad_target_q  <= bad_target_d;
        end
    end

    assign irregPc       = issue ? pend_target_q : '0;
    assign redirectIssue = issue;
    assign flushFetch    = issue || ((flush_cnt_q != 4'd0) && !rst);
    assign busy          = pend_valid_q;
    assign dropped       = !rst && (lose_drop || drop_pend);
    assign badTarget     = bad_target_q;

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// tb/tb_fetch_redirect_ctrl.sv - self-checking bench for fetch_redirect_ctrl
module tb_fetch_redirect_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        trapValid, mispredValid, replayValid;
    logic [31:0] trapTarget, mispredTarget, replayTarget;
    logic [31:0] irregPc;
    logic        redirectIssue, flushFetch, busy, dropped, badTarget;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    fetch_redirect_ctrl #(
        .ADDR_WIDTH  (32),
        .RESET_PC    (32'h0000_1000),
        .FLUSH_CYCLES(2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .trapValid    (trapValid),
        .trapTarget   (trapTarget),
        .mispredValid (mispredValid),
        .mispredTarget(mispredTarget),
        .replayValid  (replayValid),
        .replayTarget (replayTarget),
        .irregPc      (irregPc),
        .redirectIssue(redirectIssue),
        .flushFetch   (flushFetch),
        .busy         (busy),
        .dropped      (dropped),
        .badTarget    (badTarget)
    );

    typedef struct {
        logic        stall;
        logic        tv;
        logic [31:0] tt;
        logic        mv;
        logic [31:0] mt;
        logic        rv;
        logic [31:0] rt;
        logic [31:0] e_pc;
        logic        e_iss;
        logic        e_flush;
        logic        e_busy;
        logic        e_drop;
        logic        e_bad;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic s, logic tv, logic [31:0] tt, logic mv, logic [31:0] mt,
                                logic rv, logic [31:0] rt, logic [31:0] pc, logic iss,
                                logic fl, logic bu, logic dr, logic bd);
        vec_t v;
        v.stall = s;  v.tv = tv; v.tt = tt; v.mv = mv; v.mt = mt; v.rv = rv; v.rt = rt;
        v.e_pc = pc;  v.e_iss = iss; v.e_flush = fl; v.e_busy = bu; v.e_drop = dr; v.e_bad = bd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        else
            n_pass++;
    endtask

    task automatic drive(input logic s, input logic tv, input logic [31:0] tt, input logic mv,
                         input logic [31:0] mt, input logic rv, input logic [31:0] rt);
        stall = s; trapValid = tv; trapTarget = tt;
        mispredValid = mv; mispredTarget = mt; replayValid = rv; replayTarget = rt;
    endtask

    task automatic chk_all(input string tag, input logic [31:0] pc, input logic iss,
                           input logic fl, input logic bu, input logic dr, input logic bd);
        chk({tag, "_pc"},    irregPc,               pc);
        chk({tag, "_issue"}, {31'd0, redirectIssue}, {31'd0, iss});
        chk({tag, "_flush"}, {31'd0, flushFetch},    {31'd0, fl});
        chk({tag, "_busy"},  {31'd0, busy},          {31'd0, bu});
        chk({tag, "_drop"},  {31'd0, dropped},       {31'd0, dr});
        chk({tag, "_bad"},   {31'd0, badTarget},     {31'd0, bd});
    endtask

    initial begin
        // Boot under stall, then boot issue and its flush window
        for (int i = 0; i < 5; i++) vecs.push_back(mk(1,0,0,0,0,0,0, 0,0,0,1,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0, 32'h1000,1,1,1,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0, 0,0,1,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0, 0,0,1,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0, 0,0,0,0,0,0));
        // Simple mispredict redirect
        vecs.push_back(mk(0,0,0,1,32'h200,0,0, 0,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0, 32'h200,1,1,1,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0, 0,0,1,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0, 0,0,1,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0, 0,0,0,0,0,0));
        // Same-cycle priority, then pending vs newcomers under stall
        vecs.push_back(mk(0,1,32'h100,1,32'h200,1,32'h300, 0,0,0,0,1,0));
        vecs.push_back(mk(0,0,0,0,0,0,0, 32'h100,1,1,1,0,0));
        vecs.push_back(mk(1,0,0,1,32'h200,0,0, 0,0,1,0,0,0));
        vecs.push_back(mk(1,0,0,0,0,1,32'h300, 0,0,1,1,1,0));
        vecs.push_back(mk(1,1,32'h400,0,0,0,0, 0,0,1,1,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0, 32'h400,1,1,1,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0, 0,0,1,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0, 0,0,1,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0, 0,0,0,0,0,0));
        // Issue-cycle collision: flush counter must reload on the second issue
        vecs.push_back(mk(0,0,0,1,32'h200,0,0, 0,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,1,32'h500, 32'h200,1,1,1,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0, 32'h500,1,1,1,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0, 0,0,1,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0, 0,0,1,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0, 0,0,0,0,0,0));
        // Equal priority: newest wins
        vecs.push_back(mk(1,0,0,1,32'h700,0,0, 0,0,0,0,0,0));
        vecs.push_back(mk(1,0,0,1,32'h704,0,0, 0,0,0,1,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0, 32'h704,1,1,1,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0, 0,0,1,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0, 0,0,1,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0, 0,0,0,0,0,0));
        // Bad targets: zero, misaligned, and a bad trap over a good pending entry
        vecs.push_back(mk(0,1,32'h0,0,0,0,0, 0,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,1,32'h102,0,0, 0,0,0,0,0,1));
        vecs.push_back(mk(0,0,0,0,0,0,0, 0,0,0,0,0,1));
        vecs.push_back(mk(1,0,0,1,32'h800,0,0, 0,0,0,0,0,1));
        vecs.push_back(mk(1,1,32'h3,0,0,0,0, 0,0,0,1,0,1));
        vecs.push_back(mk(0,0,0,0,0,0,0, 32'h800,1,1,1,0,1));
        vecs.push_back(mk(0,0,0,0,0,0,0, 0,0,1,0,0,1));
        vecs.push_back(mk(0,0,0,0,0,0,0, 0,0,1,0,0,1));
        vecs.push_back(mk(0,0,0,0,0,0,0, 0,0,0,0,0,1));

        rst = 1'b1;
        drive(0,0,0,0,0,0,0);
        @(negedge clk);
        @(negedge clk);
        #1;
        chk_all("reset", 0, 0, 0, 1, 0, 0);

        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < vecs.size(); i++) begin
            if (i != 0) @(negedge clk);
            drive(vecs[i].stall, vecs[i].tv, vecs[i].tt, vecs[i].mv, vecs[i].mt,
                  vecs[i].rv, vecs[i].rt);
            #1;
            chk_all($sformatf("row%0d", i), vecs[i].e_pc, vecs[i].e_iss, vecs[i].e_flush,
                    vecs[i].e_busy, vecs[i].e_drop, vecs[i].e_bad);
        end

        // Reset clears sticky badTarget and restores the boot redirect
        @(negedge clk);
        rst = 1'b1;
        drive(0,0,0,0,0,0,0);
        #1;
        chk_all("rst2", 0, 0, 0, 1, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_all("boot2", 32'h1000, 1, 1, 1, 0, 0);

        // Async reset mid-flush with 0x600 pending under stall
        @(negedge clk);
        drive(0,0,0,1,32'h200,0,0);
        #1;
        chk_all("mf_req", 0, 0, 1, 0, 0, 0);
        @(negedge clk);
        drive(0,0,0,0,0,0,0);
        #1;
        chk_all("mf_iss", 32'h200, 1, 1, 1, 0, 0);
        @(negedge clk);
        drive(1,0,0,1,32'h600,0,0);
        #1;
        chk_all("mf_cap", 0, 0, 1, 0, 0, 0);
        @(negedge clk);
        drive(1,0,0,0,0,0,0);
        #1;
        chk_all("mf_hold", 0, 0, 1, 1, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        chk_all("mf_rst", 0, 0, 0, 1, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_all("mf_rel", 0, 0, 0, 1, 0, 0);
        @(negedge clk);
        stall = 1'b0;
        #1;
        chk_all("mf_boot", 32'h1000, 1, 1, 1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            chk($sformatf("mf_after%0d_pc", i), irregPc, 0);
            chk($sformatf("mf_after%0d_busy", i), {31'd0, busy}, 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
